// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, header length and bus width.
package prog_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned HDR_LEN        = 2;
    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs little-endian bytes into instruction words and emits a one-cycle completion pulse.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              last_byte,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned IdxW  = $clog2(BYTES_PER_WORD);
    localparam int unsigned PartW = WORD_W - 8;

    logic [IdxW-1:0]   idx_q;
    logic [PartW-1:0]  part_q;
    logic [WORD_W-1:0] word_q;
    logic              done_q;

    assign last_byte = (idx_q == IdxW'(BYTES_PER_WORD - 1));
    assign word_done = done_q;
    assign word      = word_q;

    // word_q only changes on completion, so the write data holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            part_q <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else if (clear) begin
            idx_q  <= '0;
            part_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= byte_valid && last_byte;
            if (byte_valid) begin
                idx_q <= idx_q + IdxW'(1);
                if (last_byte) begin
                    word_q <= {byte_data, part_q};
                    part_q <= '0;
                end else begin
                    for (int k = 0; k < int'(BYTES_PER_WORD) - 1; k++) begin
                        if (idx_q == IdxW'(k)) begin
                            part_q[8*k +: 8] <= byte_data;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory, then enables the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    output logic              run,
    output logic              busy,
    output logic              err
);

    localparam int unsigned NCountW = 8 * HDR_LEN;
    localparam int unsigned CmpW    = NCountW + 1;
    localparam logic [CmpW-1:0] Depth = CmpW'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic [7:0]          n_lo_q;
    logic [NCountW-1:0]  n_q;
    logic [NCountW-1:0]  n_full;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                accept, byte_valid, wr_fire, last_done, hdr_bad, asm_clear;
    logic                last_byte, word_done;
    logic [WORD_W-1:0]   word;

    // rst_n gates in_ready so nothing is offered while reset is held
    assign in_ready   = rst_n && !reload &&
                        (state_q inside {StHdr0, StHdr1, StData});
    assign accept     = in_valid && in_ready;
    assign byte_valid = accept && (state_q == StData);
    assign wr_fire    = byte_valid && last_byte;
    assign n_full     = {in_data, n_lo_q};
    assign hdr_bad    = (n_full == '0) || (CmpW'(n_full) > Depth);
    // cnt_q already counts the pulsing word, so equality marks the final write
    assign last_done  = word_done && (CmpW'(cnt_q) == CmpW'(n_q));
    assign asm_clear  = reload || (state_q != StData) || last_done;

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (byte_valid),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_done  (word_done),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = StHdr0;
        end else begin
            unique case (state_q)
                StHdr0: if (accept) state_d = StHdr1;
                StHdr1: if (accept) state_d = hdr_bad ? StErr : StData;
                StData: if (last_done) state_d = StDone;
                StDone: state_d = StDone;
                StErr:  state_d = StErr;
                default: state_d = StHdr0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHdr0;
            n_lo_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (reload) begin
                n_lo_q <= '0;
                n_q    <= '0;
                cnt_q  <= '0;
            end else begin
                if (accept && state_q == StHdr0) n_lo_q <= in_data;
                if (accept && state_q == StHdr1) n_q <= n_full;
                if (state_q != StData) begin
                    cnt_q <= '0;
                end else if (wr_fire) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (wr_fire) addr_q <= cnt_q[ADDR_W-1:0];
            end
        end
    end

    assign mem_wr_en   = word_done;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = word;
    assign run         = (state_q == StDone);
    assign err         = (state_q == StErr);
    assign busy        = (state_q inside {StHdr1, StData});

endmodule
